// File: rtl/spi_blink_regs_pkg.sv
// Shared definitions for the SPI register bank: register addresses, CTRL bit
// positions, command-byte layout and framing states.
package spi_blink_regs_pkg;

    localparam logic [6:0] ADDR_CTRL     = 7'h00;
    localparam logic [6:0] ADDR_PERIOD_L = 7'h01;
    localparam logic [6:0] ADDR_PERIOD_H = 7'h02;
    localparam logic [6:0] ADDR_STATUS   = 7'h03;
    localparam logic [6:0] ADDR_ID       = 7'h04;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_INV_BIT = 1;
    localparam int RW_BIT       = 7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } frame_state_t;

endpackage

// File: rtl/spi_blink_regs_if.sv
// Byte-level link between the SPI byte receiver and the register bank,
// including the readback path toward a future MISO shifter.
interface spi_blink_regs_if;
    logic       i_rx_done;
    logic [7:0] i_rx_data;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       o_err;

    modport master (output i_rx_done, i_rx_data, input o_tx_data, o_tx_valid, o_err);
    modport slave  (input i_rx_done, i_rx_data, output o_tx_data, o_tx_valid, o_err);
endinterface

// File: rtl/spi_blink_regs_blink_timer.sv
// LED blink time base: tick prescaler, half-period tick counter and output phase.
module blink_timer #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic [15:0] i_period,
    input  logic        i_restart,
    output logic        o_phase
);
    localparam int PRESC_N = CLK_HZ / TICK_HZ;
    localparam int PRESC_W = $clog2(PRESC_N);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESC_N - 1);

    logic [PRESC_W-1:0] r_presc;
    logic [15:0]        r_count;
    logic               r_phase;
    logic               w_tick;

    assign w_tick  = (r_presc == PRESC_MAX);
    assign o_phase = r_phase;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc <= '0;
            r_count <= '0;
            r_phase <= 1'b0;
        end else if (!i_enable || (i_period == 16'd0) || i_restart) begin
            // Held idle so a later enable/commit starts cleanly at phase 0, count 0.
            r_presc <= '0;
            r_count <= '0;
            r_phase <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
            if (w_tick) begin
                if (r_count == i_period - 16'd1) begin
                    r_count <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_count <= r_count + 16'd1;
                end
            end
        end
    end
endmodule

// File: rtl/spi_blink_regs.sv
// SPI register bank: frames received bytes by CSn, decodes command + auto-increment
// data into CTRL/PERIOD registers and drives the LED blink timer.
//   state   | meaning
//   ST_IDLE | waiting for the command byte of a frame
//   ST_DATA | command latched; each byte accesses addr, then addr++
module spi_blink_regs
    import spi_blink_regs_pkg::*;
#(
    parameter int          CLK_HZ         = 50_000_000,
    parameter int          TICK_HZ        = 1000,
    parameter logic [7:0]  ID_VALUE       = 8'hA5,
    parameter logic [15:0] DEFAULT_PERIOD = 16'd500
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_spi_s_cs_n,
    spi_blink_regs_if.slave   bus,
    output logic              o_led
);
    frame_state_t r_state, w_state_nxt;
    logic        r_cs_sync1, r_cs_sync2;
    logic        r_rw;
    logic [6:0]  r_addr;
    logic [1:0]  r_ctrl;
    logic [7:0]  r_shadow;
    logic [15:0] r_period;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid, r_err, r_led;

    logic        w_cs_hi, w_byte, w_is_cmd, w_is_data, w_do_read, w_do_write, w_restart;
    logic        w_phase, w_rd_err;
    logic [6:0]  w_rd_addr;
    logic [7:0]  w_rd_data;

    assign w_cs_hi    = r_cs_sync2;
    // CS high wins over a coincident byte: the byte is dropped entirely.
    assign w_byte     = bus.i_rx_done & ~w_cs_hi;
    assign w_is_cmd   = w_byte & (r_state == ST_IDLE);
    assign w_is_data  = w_byte & (r_state == ST_DATA);
    assign w_do_read  = (w_is_cmd & ~bus.i_rx_data[RW_BIT]) | (w_is_data & ~r_rw);
    assign w_do_write = w_is_data & r_rw;
    assign w_restart  = w_do_write & (r_addr == ADDR_PERIOD_H);
    assign w_rd_addr  = (r_state == ST_IDLE) ? bus.i_rx_data[6:0] : r_addr;

    always_comb begin
        w_rd_data = 8'h00;
        w_rd_err  = 1'b0;
        case (w_rd_addr)
            ADDR_CTRL:     w_rd_data = {6'b0, r_ctrl};
            ADDR_PERIOD_L: w_rd_data = r_period[7:0];
            ADDR_PERIOD_H: w_rd_data = r_period[15:8];
            ADDR_STATUS:   w_rd_data = {7'b0, r_led};
            ADDR_ID:       w_rd_data = ID_VALUE;
            default:       w_rd_err  = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_cs_hi)       w_state_nxt = ST_IDLE;
        else if (w_is_cmd) w_state_nxt = ST_DATA;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_cs_sync1 <= 1'b1;
            r_cs_sync2 <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cs_sync1 <= i_spi_s_cs_n;
            r_cs_sync2 <= r_cs_sync1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rw       <= 1'b0;
            r_addr     <= '0;
            r_ctrl     <= '0;
            r_shadow   <= '0;
            r_period   <= DEFAULT_PERIOD;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_err      <= 1'b0;
            r_led      <= 1'b0;
        end else begin
            r_tx_valid <= 1'b0;
            r_err      <= 1'b0;
            r_led      <= w_phase ^ r_ctrl[CTRL_INV_BIT];
            if (w_is_cmd) begin
                r_rw   <= bus.i_rx_data[RW_BIT];
                r_addr <= bus.i_rx_data[RW_BIT] ? bus.i_rx_data[6:0]
                                                : bus.i_rx_data[6:0] + 7'd1;
            end
            if (w_is_data) r_addr <= r_addr + 7'd1;
            if (w_do_read) begin
                r_tx_data  <= w_rd_data;
                r_tx_valid <= 1'b1;
                r_err      <= w_rd_err;
            end
            if (w_do_write) begin
                case (r_addr)
                    ADDR_CTRL:     r_ctrl   <= bus.i_rx_data[1:0];
                    ADDR_PERIOD_L: r_shadow <= bus.i_rx_data;
                    ADDR_PERIOD_H: r_period <= {bus.i_rx_data, r_shadow};
                    default:       r_err    <= 1'b1;
                endcase
            end
        end
    end

    blink_timer #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_blink_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_enable  (r_ctrl[CTRL_EN_BIT]),
        .i_period  (r_period),
        .i_restart (w_restart),
        .o_phase   (w_phase)
    );

    assign bus.o_tx_data  = r_tx_data;
    assign bus.o_tx_valid = r_tx_valid;
    assign bus.o_err      = r_err;
    assign o_led          = r_led;
endmodule

// File: tb/tb_spi_blink_regs.sv
// Scoreboard bench for spi_blink_regs: stimulus queues expected readback/err
// pulses, a monitor pops and compares them; LED timing is checked directly.
module tb_spi_blink_regs;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cs_n = 1'b1;
    logic led;

    always #5 clk = ~clk;

    spi_blink_regs_if bus();

    spi_blink_regs #(
        .CLK_HZ(10_000), .TICK_HZ(1000), .ID_VALUE(8'hA5), .DEFAULT_PERIOD(16'd500)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_spi_s_cs_n(cs_n), .bus(bus), .o_led(led)
    );

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_rd(input logic [7:0] d, input logic e);
        exp_q.push_back({1'b1, d, e});
    endtask

    task automatic push_err();
        exp_q.push_back({1'b0, 8'h00, 1'b1});
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        @(negedge clk);
        bus.i_rx_done = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic cs_lo();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic cs_hi();
        @(negedge clk);
        cs_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        cs_lo();
        send_byte(b0);
        if (n > 1) send_byte(b1);
        if (n > 2) send_byte(b2);
        cs_hi();
    endtask

    task automatic led_interval(output int cycles);
        logic prev;
        prev = led;
        cycles = 0;
        while (led === prev && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (bus.o_tx_valid === 1'b1 || bus.o_err === 1'b1)) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse: got valid=%0b data=%02h err=%0b, required no pulse",
                             bus.o_tx_valid, bus.o_tx_data, bus.o_err);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.o_tx_valid !== e.valid || bus.o_err !== e.err ||
                        (e.valid && bus.o_tx_data !== e.data)) begin
                        n_fail++;
                        $display("FAIL readback: got valid=%0b data=%02h err=%0b, required valid=%0b data=%02h err=%0b",
                                 bus.o_tx_valid, bus.o_tx_data, bus.o_err, e.valid, e.data, e.err);
                    end
                end
            end
        end
    end

    initial begin
        repeat (90_000) @(posedge clk);
        $display("FAIL watchdog: got no finish, required finish within 90000 clocks");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        bus.i_rx_done = 1'b0;
        bus.i_rx_data = 8'h00;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_led", 32'(led), 32'd0);
        check("reset_tx_valid", 32'(bus.o_tx_valid), 32'd0);
        check("reset_err", 32'(bus.o_err), 32'd0);
        check("reset_tx_data", 32'(bus.o_tx_data), 32'h00);
        repeat (1000) @(negedge clk);
        check("idle_led", 32'(led), 32'd0);

        // Default PERIOD = 500 = 0x01F4
        push_rd(8'hF4, 1'b0); push_rd(8'h01, 1'b0);
        frame(2, 8'h01, 8'hFF, 8'h00);

        // STATUS, ID, then invalid 0x05
        push_rd(8'h00, 1'b0); push_rd(8'hA5, 1'b0); push_rd(8'h00, 1'b1);
        frame(3, 8'h03, 8'hFF, 8'hFF);

        // PERIOD_L goes to shadow only; PERIOD_H commits
        frame(2, 8'h81, 8'h34, 8'h00);
        push_rd(8'hF4, 1'b0);
        frame(1, 8'h01, 8'h00, 8'h00);
        frame(2, 8'h82, 8'h12, 8'h00);
        push_rd(8'h34, 1'b0); push_rd(8'h12, 1'b0);
        frame(2, 8'h01, 8'hFF, 8'h00);

        // PERIOD = 10 ticks = 100 clocks at the scaled clock, then enable
        frame(3, 8'h81, 8'h0A, 8'h00);
        frame(2, 8'h80, 8'h01, 8'h00);
        led_interval(cyc);
        for (int i = 0; i < 3; i++) begin
            led_interval(cyc);
            check("blink_interval", 32'(cyc), 32'd100);
        end
        push_rd(8'h0A, 1'b0); push_rd(8'h00, 1'b0);
        frame(2, 8'h01, 8'hFF, 8'h00);

        // Data byte coincident with synced CSn high is dropped
        cs_lo();
        send_byte(8'h80);
        @(negedge clk);
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
        bus.i_rx_data = 8'h00;
        bus.i_rx_done = 1'b1;
        @(negedge clk);
        bus.i_rx_done = 1'b0;
        repeat (4) @(negedge clk);
        push_rd(8'h01, 1'b0);
        frame(1, 8'h00, 8'h00, 8'h00);

        // Disable, then write to read-only STATUS
        frame(2, 8'h80, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        check("disabled_led", 32'(led), 32'd0);
        push_err();
        frame(2, 8'h83, 8'h55, 8'h00);
        push_rd(8'h00, 1'b0);
        frame(1, 8'h03, 8'h00, 8'h00);

        // enable+invert with PERIOD=0 -> steady high
        frame(2, 8'h80, 8'h03, 8'h00);
        frame(3, 8'h81, 8'h00, 8'h00);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check("steady_led", 32'(led), 32'd1);
            repeat (40) @(negedge clk);
        end
        push_rd(8'h01, 1'b0);
        frame(1, 8'h03, 8'h00, 8'h00);

        // Address 0x7F invalid, then wraps to CTRL
        push_rd(8'h00, 1'b1); push_rd(8'h03, 1'b0);
        frame(2, 8'h7F, 8'hFF, 8'h00);

        repeat (20) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
